// File: rtl/i2c_bit_driver.sv
// i2c_bit_driver: executes one START, STOP, WRITE-bit or READ-bit command at a
// time on the I2C pins. Each command is split into four quarters. SCL and SDA
// are driven as open-drain enables, and the conditioned line levels are read back
// for clock stretching, read data and arbitration.
module i2c_bit_driver #(
    parameter int CLKS_PER_QUARTER = 4
) (
    input  logic       control_clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic       cmd_bit,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       done,
    output logic       rx_bit,
    output logic       arb_lost
);

    localparam int QW = $clog2(CLKS_PER_QUARTER);
    localparam logic [QW-1:0] QLAST = QW'(CLKS_PER_QUARTER - 1);

    typedef enum logic [2:0] {
        IDLE,
        Q0,
        Q1,
        Q2,
        Q3
    } state_t;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    cmd_t          cur_cmd;
    logic          cur_bit;

    logic q_last;
    logic stall;
    logic arb_hit;
    logic sample_now;

    // Line enables {scl_oe, sda_oe} for a given command and quarter index.
    function automatic logic [1:0] line_drive(input cmd_t c, input logic b, input logic [1:0] q);
        logic [1:0] r;
        r = 2'b00;
        case (c)
            CMD_START: begin
                case (q)
                    2'd0:    r = 2'b00;
                    2'd1:    r = 2'b00;
                    2'd2:    r = 2'b01;
                    default: r = 2'b11;
                endcase
            end
            CMD_STOP: begin
                case (q)
                    2'd0:    r = 2'b11;
                    2'd1:    r = 2'b01;
                    2'd2:    r = 2'b01;
                    default: r = 2'b00;
                endcase
            end
            CMD_WRITE: r = {(q == 2'd0) || (q == 2'd3), ~b};
            default:   r = {(q == 2'd0) || (q == 2'd3), 1'b0};
        endcase
        return r;
    endfunction

    // A slave holding SCL low freezes the first cycle of Q1.
    assign q_last     = (qcnt == QLAST);
    assign stall      = (state == Q1) && (qcnt == '0) && !scl_in;
    assign sample_now = (state == Q2) && q_last && ((cur_cmd == CMD_WRITE) || (cur_cmd == CMD_READ));
    assign arb_hit    = sample_now && (cur_cmd == CMD_WRITE) && cur_bit && !sda_in;

    assign cmd_ready = (state == IDLE);
    assign arb_lost  = arb_hit;
    assign done      = ((state == Q3) && q_last) || arb_hit;

    // Quarter sequencing, registered line drive and bit sampling.
    always_ff @(posedge control_clock) begin
        if (reset) begin
            state   <= IDLE;
            qcnt    <= '0;
            cur_cmd <= CMD_START;
            cur_bit <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            rx_bit  <= 1'b0;
        end else begin
            if (sample_now) begin
                rx_bit <= sda_in;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_cmd            <= cmd_t'(cmd);
                        cur_bit            <= cmd_bit;
                        qcnt               <= '0;
                        state              <= Q0;
                        {scl_oe, sda_oe}   <= line_drive(cmd_t'(cmd), cmd_bit, 2'd0);
                    end
                end
                default: begin
                    if (stall) begin
                        qcnt <= '0;
                    end else if (arb_hit) begin
                        qcnt             <= '0;
                        state            <= IDLE;
                        {scl_oe, sda_oe} <= 2'b00;
                    end else if (q_last) begin
                        qcnt <= '0;
                        case (state)
                            Q0: begin
                                state            <= Q1;
                                {scl_oe, sda_oe} <= line_drive(cur_cmd, cur_bit, 2'd1);
                            end
                            Q1: begin
                                state            <= Q2;
                                {scl_oe, sda_oe} <= line_drive(cur_cmd, cur_bit, 2'd2);
                            end
                            Q2: begin
                                state            <= Q3;
                                {scl_oe, sda_oe} <= line_drive(cur_cmd, cur_bit, 2'd3);
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_driver.sv
// tb_i2c_bit_driver: directed and randomized commands against a cycle-level
// reference built from quarter lengths and the per-command drive table.
module tb_i2c_bit_driver;

    localparam int Q = 4;

    logic       control_clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = 2'd0;
    logic       cmd_bit = 1'b0;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       done;
    logic       rx_bit;
    logic       arb_lost;

    logic stretch_hold = 1'b0;
    logic sda_low = 1'b0;

    int tests = 0;
    int errors = 0;

    logic exp_scl = 1'b0;
    logic exp_sda = 1'b0;
    logic exp_rx  = 1'b0;

    i2c_bit_driver #(.CLKS_PER_QUARTER(Q)) dut (
        .control_clock(control_clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd          (cmd),
        .cmd_bit      (cmd_bit),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .scl_oe       (scl_oe),
        .sda_oe       (sda_oe),
        .done         (done),
        .rx_bit       (rx_bit),
        .arb_lost     (arb_lost)
    );

    // Open-drain bus: a line reads low if either side pulls it.
    assign scl_in = ~scl_oe & ~stretch_hold;
    assign sda_in = ~sda_oe & ~sda_low;

    // Free-running control clock.
    always #5 control_clock = ~control_clock;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic got, input logic expv);
        tests++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", tag, $time, got, expv);
        end
    endtask

    // Reference drive table {scl_oe, sda_oe} per command and quarter.
    function automatic logic [1:0] quarterDrive(input logic [1:0] c, input logic b, input int q);
        logic [1:0] start_t [4];
        logic [1:0] stop_t  [4];
        logic       clk_t   [4];
        start_t = '{2'b00, 2'b00, 2'b01, 2'b11};
        stop_t  = '{2'b11, 2'b01, 2'b01, 2'b00};
        clk_t   = '{1'b1, 1'b0, 1'b0, 1'b1};
        case (c)
            2'd0:    return start_t[q];
            2'd1:    return stop_t[q];
            2'd2:    return {clk_t[q], ~b};
            default: return {clk_t[q], 1'b0};
        endcase
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready"}, cmd_ready, 1'b1);
        checkOutput({tag, "_scl"}, scl_oe, exp_scl);
        checkOutput({tag, "_sda"}, sda_oe, exp_sda);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_arb"}, arb_lost, 1'b0);
        checkOutput({tag, "_rx"}, rx_bit, exp_rx);
    endtask

    task automatic idleGap(input int cycles);
        cmd_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge control_clock);
            checkIdle("idle");
            @(posedge control_clock);
            #1;
        end
    endtask

    // Issue one command in the current IDLE cycle and follow it cycle by cycle.
    // n = stretch cycles at Q1 entry; abort_idx >= 0 asserts reset on that busy cycle.
    task automatic applyStimulus(input logic [1:0] c, input logic b, input logic low,
                                 input int n, input int abort_idx);
        logic [1:0] drv;
        logic       arb;
        logic       last;
        int         idx;
        int         qlen;
        arb = (c == 2'd2) && b && low;
        cmd_valid    = 1'b1;
        cmd          = c;
        cmd_bit      = b;
        sda_low      = low;
        stretch_hold = 1'b0;
        @(negedge control_clock);
        checkIdle("accept");
        @(posedge control_clock);
        #1;
        idx = 0;
        for (int q = 0; q < 4; q++) begin
            if (arb && q == 3) break;
            qlen = (q == 1) ? Q + n : Q;
            for (int k = 0; k < qlen; k++) begin
                cmd_valid    = 1'($urandom);
                cmd          = 2'($urandom);
                cmd_bit      = 1'($urandom);
                stretch_hold = (q == 1) && (k < n);
                if (idx == abort_idx) reset = 1'b1;
                drv  = quarterDrive(c, b, q);
                last = (k == qlen - 1);
                @(negedge control_clock);
                checkOutput("busy_scl", scl_oe, drv[1]);
                checkOutput("busy_sda", sda_oe, drv[0]);
                checkOutput("busy_ready", cmd_ready, 1'b0);
                checkOutput("busy_done", done, ((q == 3) && last) || (arb && (q == 2) && last));
                checkOutput("busy_arb", arb_lost, arb && (q == 2) && last);
                checkOutput("busy_rx", rx_bit, exp_rx);
                @(posedge control_clock);
                #1;
                if (idx == abort_idx) begin
                    reset        = 1'b0;
                    cmd_valid    = 1'b0;
                    stretch_hold = 1'b0;
                    exp_scl      = 1'b0;
                    exp_sda      = 1'b0;
                    exp_rx       = 1'b0;
                    return;
                end
                if ((q == 2) && last && c[1]) begin
                    exp_rx = (c == 2'd3) ? ~low : (b & ~low);
                end
                idx++;
            end
        end
        cmd_valid    = 1'b0;
        stretch_hold = 1'b0;
        if (arb) begin
            exp_scl = 1'b0;
            exp_sda = 1'b0;
        end else begin
            drv     = quarterDrive(c, b, 3);
            exp_scl = drv[1];
            exp_sda = drv[0];
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge control_clock);
        #1;
        @(negedge control_clock);
        checkIdle("reset");
        @(posedge control_clock);
        #1;
        reset = 1'b0;

        // START, WRITE 0, WRITE 1, READ 1
        applyStimulus(2'd0, 1'b0, 1'b0, 0, -1);
        applyStimulus(2'd2, 1'b0, 1'b0, 0, -1);
        applyStimulus(2'd2, 1'b1, 1'b0, 0, -1);
        applyStimulus(2'd3, 1'b0, 1'b0, 0, -1);
        // arbitration loss on WRITE 1
        applyStimulus(2'd2, 1'b1, 1'b1, 0, -1);
        idleGap(1);
        // READ with a 10-cycle clock stretch
        applyStimulus(2'd3, 1'b0, 1'b1, 10, -1);
        // reset in Q2 of STOP, then a normal START
        applyStimulus(2'd1, 1'b0, 1'b0, 0, 2 * Q + 1);
        idleGap(1);
        applyStimulus(2'd0, 1'b0, 1'b0, 0, -1);

        // randomized command stream
        for (int i = 0; i < 80; i++) begin
            logic [1:0] c;
            int         n;
            c = 2'($urandom);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            idleGap($urandom_range(0, 2));
            applyStimulus(c, 1'($urandom), 1'($urandom), n, -1);
        end
        idleGap(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
